pc_lut_loader: RTL and testbench

- Writable replacement for the fixed branch-target table: the write side that fills the fetch-stage target table at runtime instead of hard-coding targets per program.
- Accepts a byte stream of load commands over a valid/ready handshake and writes entries into an internal N-entry table of D-bit targets.
- Exposes the same read view the fetch/branch logic uses: combinational 5-bit index in, D-bit target out.
- Sits between the test-harness/boot loader byte source and the fetch unit.

---
 rtl/pc_lut_pkg.sv | 31 +++
 rtl/pc_lut_regfile.sv | 52 +++++
 rtl/pc_lut_loader.sv | 166 ++++++++++++++++
 tb/tb_pc_lut_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_lut_pkg.sv
// ---------------------------------------------------------------------------
// pc_lut_pkg
// Shared definitions for the writable branch-target table and its loader.
//   op_e     : 2-bit opcode carried in byte0[7:6] of a load command
//   state_e  : loader FSM states
//   DEFAULT_D / DEFAULT_AW : default target width and index width, also
//              used by the fetch unit so both sides agree on the table shape
// ---------------------------------------------------------------------------
package pc_lut_pkg;

  localparam int DEFAULT_D  = 12;
  localparam int DEFAULT_AW = 5;
  localparam int DEFAULT_N  = 1 << DEFAULT_AW;

  // Command opcodes in byte0[7:6]
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_END   = 2'b11
  } op_e;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WR_HI = 2'b01,
    ST_WR_LO = 2'b10,
    ST_CLEAR = 2'b11
  } state_e;

endpackage

// File: rtl/pc_lut_regfile.sv
// ---------------------------------------------------------------------------
// pc_lut_regfile
// N x D flop array holding branch targets.
//   clk      : system clock
//   reset    : synchronous active-high reset, zeroes every entry
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write data
//   i_raddr  : read index (fetch side)
//   o_rdata  : read data, combinational from the array
// Entry 0 is the "hold PC" default and always reads 0; writes to it are
// dropped so the fetch unit can rely on that entry never moving.
// ---------------------------------------------------------------------------
module pc_lut_regfile
  import pc_lut_pkg::*;
#(
  parameter int D  = DEFAULT_D,
  parameter int AW = DEFAULT_AW,
  parameter int N  = 1 << AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [D-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [D-1:0]  o_rdata
);

  logic [D-1:0] r_mem [N];

  // Single synchronous write port. Reset clears the whole array in one
  // edge so an interrupted load never leaves stale targets behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read; index 0 is forced to zero regardless of storage.
  always_comb begin
    o_rdata = '0;
    if (i_raddr != '0) begin
      o_rdata = r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/pc_lut_loader.sv
// ---------------------------------------------------------------------------
// pc_lut_loader
// Runtime loader for the fetch-stage branch-target table. Consumes a byte
// stream of load commands over valid/ready and writes the table; exposes
// the combinational read view used by fetch/branch logic.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   in_valid   : command byte valid
//   in_data    : command byte
//   in_ready   : loader accepts in_data this cycle (state only)
//   rd_addr    : fetch-side table index
//   rd_target  : fetch-side target, combinational from table
//   loaded     : END seen since last reset/CLEAR
//   busy       : CLEAR sweep or multi-byte WRITE in progress
//   err        : sticky protocol error (reserved bit, index 0 write,
//                or high target byte wider than D-8 bits)
// byte0: [7:6]=op, [5]=reserved, [4:0]=index. WRITE is followed by the
// high target byte then the low target byte.
// ---------------------------------------------------------------------------
module pc_lut_loader
  import pc_lut_pkg::*;
#(
  parameter int D  = DEFAULT_D,
  parameter int N  = DEFAULT_N,
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [D-1:0]  rd_target,
  output logic          loaded,
  output logic          busy,
  output logic          err
);

  state_e        r_state;
  state_e        w_nextState;
  logic [AW-1:0] r_idx;
  logic [D-9:0]  r_hi;
  logic [AW-1:0] r_cnt;
  logic          r_loaded;
  logic          r_err;

  logic          w_fire;
  op_e           w_op;
  logic          w_hiOverflow;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [D-1:0]  w_wdata;

  assign in_ready = (r_state != ST_CLEAR);
  assign busy     = (r_state != ST_IDLE);
  assign loaded   = r_loaded;
  assign err      = r_err;

  assign w_fire       = in_valid && in_ready;
  assign w_op         = op_e'(in_data[7:6]);
  // Bits of the high byte that cannot fit in a D-bit target
  assign w_hiOverflow = ((in_data >> (D - 8)) != 8'd0);

  // Next-state and table write port. The final WRITE byte and every CLEAR
  // cycle share the single regfile write port.
  always_comb begin
    w_nextState = r_state;
    w_we        = 1'b0;
    w_waddr     = r_idx;
    w_wdata     = {r_hi, in_data};
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          case (w_op)
            OP_WRITE: w_nextState = ST_WR_HI;
            OP_CLEAR: w_nextState = ST_CLEAR;
            default:  w_nextState = ST_IDLE;
          endcase
        end
      end
      ST_WR_HI: begin
        if (w_fire) begin
          w_nextState = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (w_fire) begin
          w_we        = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = '0;
        if (r_cnt == AW'(N - 1)) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register plus the command-side bookkeeping: latched index and
  // high bits, sweep counter, and the loaded/err flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_hi     <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (in_data[5]) begin
              r_err <= 1'b1;
            end
            case (w_op)
              OP_WRITE: begin
                r_idx <= in_data[AW-1:0];
                if (in_data[AW-1:0] == '0) begin
                  r_err <= 1'b1;
                end
              end
              OP_CLEAR: begin
                r_cnt    <= '0;
                r_loaded <= 1'b0;
              end
              OP_END:   r_loaded <= 1'b1;
              default:  ;
            endcase
          end
        end
        ST_WR_HI: begin
          if (w_fire) begin
            r_hi <= in_data[D-9:0];
            if (w_hiOverflow) begin
              r_err <= 1'b1;
            end
          end
        end
        ST_CLEAR: r_cnt <= r_cnt + 1'b1;
        default:  ;
      endcase
    end
  end

  pc_lut_regfile #(
    .D  (D),
    .AW (AW),
    .N  (N)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_target)
  );

endmodule

// File: tb/tb_pc_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_pc_lut_loader
// Directed bench for pc_lut_loader with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_pc_lut_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [4:0]  rd_addr;
  logic [11:0] rd_target;
  logic        loaded;
  logic        busy;
  logic        err;

  int checkCount;
  int failCount;

  pc_lut_loader #(.D(12), .N(32), .AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_addr   (rd_addr),
    .rd_target (rd_target),
    .loaded    (loaded),
    .busy      (busy),
    .err       (err)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one byte at a negedge, hold until accepted, release after edge
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waitCycles = 0;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 100) checkOutput("readyTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Idle cycles with junk on in_data that must be ignored
  task automatic gapCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hFF;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [4:0] a,
                           input logic [11:0] expected);
    rd_addr = a;
    #1;
    checkOutput(tag, {20'd0, rd_target}, {20'd0, expected});
  endtask

  task automatic sweepZero(input string tag);
    for (int i = 0; i < 32; i++) begin
      readCheck(tag, 5'(i), 12'd0);
    end
  endtask

  // Main directed sequence
  initial begin
    int clearCycles;
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    rd_addr    = 5'd0;

    // Reset state
    doReset();
    sweepZero("resetSweep");
    checkOutput("resetReady",  {31'd0, in_ready}, 32'd1);
    checkOutput("resetLoaded", {31'd0, loaded},   32'd0);
    checkOutput("resetBusy",   {31'd0, busy},     32'd0);
    checkOutput("resetErr",    {31'd0, err},      32'd0);

    // Back-to-back writes then END
    applyStimulus(8'h43); applyStimulus(8'h00); applyStimulus(8'h30);
    applyStimulus(8'h4E); applyStimulus(8'h00); applyStimulus(8'h60);
    applyStimulus(8'hC0);
    readCheck("idx3", 5'd3, 12'd48);
    readCheck("idx14", 5'd14, 12'd96);
    checkOutput("loadedAfterEnd", {31'd0, loaded}, 32'd1);
    checkOutput("errClean",       {31'd0, err},    32'd0);

    // Same load with valid gaps between bytes
    doReset();
    readCheck("idx3AfterReset", 5'd3, 12'd0);
    applyStimulus(8'h43); gapCycles(3); applyStimulus(8'h00); gapCycles(2);
    applyStimulus(8'h30); gapCycles(1);
    applyStimulus(8'h4E); gapCycles(4); applyStimulus(8'h00); gapCycles(1);
    applyStimulus(8'h60); gapCycles(2);
    applyStimulus(8'hC0);
    readCheck("gapIdx3", 5'd3, 12'd48);
    readCheck("gapIdx14", 5'd14, 12'd96);
    checkOutput("gapLoaded", {31'd0, loaded}, 32'd1);
    checkOutput("gapErr",    {31'd0, err},    32'd0);

    // Write-visibility timing on idx31
    readCheck("idx31Before", 5'd31, 12'd0);
    checkOutput("busyIdle", {31'd0, busy}, 32'd0);
    applyStimulus(8'h5F);
    checkOutput("busyWrHi", {31'd0, busy}, 32'd1);
    readCheck("idx31WrHi", 5'd31, 12'd0);
    applyStimulus(8'h00);
    checkOutput("busyWrLo", {31'd0, busy}, 32'd1);
    readCheck("idx31WrLo", 5'd31, 12'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h74;
    #1;
    checkOutput("idx31PreEdge", {20'd0, rd_target}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("idx31PostEdge", {20'd0, rd_target}, 32'd116);
    checkOutput("busyDone",      {31'd0, busy},      32'd0);

    // CLEAR sweep: count stalled cycles, peek at partial progress
    applyStimulus(8'h80);
    checkOutput("clearBusy",   {31'd0, busy},   32'd1);
    checkOutput("clearLoaded", {31'd0, loaded}, 32'd0);
    clearCycles = 0;
    while (!in_ready && clearCycles < 100) begin
      if (clearCycles == 4) begin
        readCheck("clearSwept3",   5'd3,  12'd0);
        readCheck("clearUnswept14", 5'd14, 12'd96);
      end
      clearCycles++;
      @(posedge clk);
      #1;
    end
    checkOutput("clearCycles", clearCycles, 32'd32);
    checkOutput("clearReady",  {31'd0, in_ready}, 32'd1);
    checkOutput("clearBusyEnd", {31'd0, busy},    32'd0);
    sweepZero("clearSweep");

    // Write to index 0 is dropped and flags err; oversize high byte
    applyStimulus(8'h40); applyStimulus(8'h00); applyStimulus(8'h09);
    readCheck("idx0Hold", 5'd0, 12'd0);
    checkOutput("errIdx0", {31'd0, err}, 32'd1);
    applyStimulus(8'h41); applyStimulus(8'hF0); applyStimulus(8'h09);
    checkOutput("errSticky", {31'd0, err}, 32'd1);
    readCheck("idx1Trunc", 5'd1, 12'd9);

    // CLEAR leaves err set
    applyStimulus(8'h80);
    gapCycles(40);
    checkOutput("errAfterClear", {31'd0, err}, 32'd1);
    readCheck("idx1Cleared", 5'd1, 12'd0);

    // Reset during WR_LO abandons the write and zeroes the table
    doReset();
    applyStimulus(8'h45); applyStimulus(8'h00); applyStimulus(8'h22);
    readCheck("idx5Pre", 5'd5, 12'd34);
    applyStimulus(8'h45); applyStimulus(8'h00);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h37;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    readCheck("idx5AfterReset", 5'd5, 12'd0);
    checkOutput("midResetReady", {31'd0, in_ready}, 32'd1);
    checkOutput("midResetBusy",  {31'd0, busy},     32'd0);
    checkOutput("midResetErr",   {31'd0, err},      32'd0);
    applyStimulus(8'h45); applyStimulus(8'h00); applyStimulus(8'h37);
    readCheck("idx5Rewrite", 5'd5, 12'd55);

    // Reserved bit on a NOP sets err without side effects
    applyStimulus(8'h20);
    checkOutput("errReserved", {31'd0, err}, 32'd1);
    readCheck("idx5AfterNop", 5'd5, 12'd55);

    // WRITE after END keeps loaded and updates the table
    applyStimulus(8'hC0);
    applyStimulus(8'h46); applyStimulus(8'h01); applyStimulus(8'h23);
    readCheck("idx6Late", 5'd6, 12'h123);
    checkOutput("loadedKept", {31'd0, loaded}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
